next_pc_seq: RTL and testbench

NEXT_PC_SEQ -- requirements
Module: next_pc_seq

---
 rtl/next_pc_seq_if.sv | 34 +++
 rtl/next_pc_seq.sv | 99 +++++++++
 tb/tb_next_pc_seq.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/next_pc_seq_if.sv
// Control and status bundle between the decode stage and the next-PC sequencer.
// Control is driven by master; the sequencer (slave) returns the PC and return-stack status.
interface next_pc_seq_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            stall;
    logic            Beq;
    logic            Bne;
    logic            Zero;
    logic            Jump;
    logic            Jal;
    logic            Jr;
    logic [XLEN-1:0] branch_offset;
    logic [25:0]     jump_index;
    logic [XLEN-1:0] jr_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            redirect;
    logic [CW-1:0]   ras_count;
    logic            ras_mismatch;

    modport master (
        output stall, Beq, Bne, Zero, Jump, Jal, Jr, branch_offset, jump_index, jr_target,
        input  pc, pc_plus4, redirect, ras_count, ras_mismatch
    );

    modport slave (
        input  stall, Beq, Bne, Zero, Jump, Jal, Jr, branch_offset, jump_index, jr_target,
        output pc, pc_plus4, redirect, ras_count, ras_mismatch
    );
endinterface

// File: rtl/next_pc_seq.sv
// Next-PC sequencer with return-address-stack tracking; pc updates 1 cycle after selection.
// stall freezes pc and stack state. NEXT_PC_RAS_EN adds stack storage and the return-mismatch check.
module next_pc_seq #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    next_pc_seq_if.slave io
);
    localparam int            CW       = $clog2(RAS_DEPTH) + 1;
    localparam int            PW       = $clog2(RAS_DEPTH);
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   ras_count_q, ras_count_d;
    logic            ras_mismatch_q, ras_mismatch_d;

    logic            taken, jr_sel, jmp_sel, jal_sel;
    logic            push, pop, pop_req;
    logic [XLEN-1:0] pc_plus4, br_target, jmp_target;

    always_comb begin
        pc_plus4   = pc_q + XLEN'(4);
        br_target  = pc_plus4 + (io.branch_offset << 2);
        jmp_target = {pc_plus4[XLEN-1:28], io.jump_index, 2'b00};

        // Beq and Bne together cancel each other out.
        taken   = (io.Beq & ~io.Bne & io.Zero) | (io.Bne & ~io.Beq & ~io.Zero);
        jr_sel  = ~taken & io.Jr;
        jmp_sel = ~taken & ~io.Jr & (io.Jump | io.Jal);
        jal_sel = jmp_sel & io.Jal;

        pop_req = ~io.stall & jr_sel;
        pop     = pop_req & (ras_count_q != '0);
        push    = ~io.stall & jal_sel;

        pc_d = pc_q;
        if (!io.stall) begin
            if (taken)        pc_d = br_target;
            else if (jr_sel)  pc_d = io.jr_target;
            else if (jmp_sel) pc_d = jmp_target;
            else              pc_d = pc_plus4;
        end

        // A push into a full stack overwrites the oldest entry, so the count saturates.
        ras_count_d = ras_count_q;
        if (push) begin
            if (ras_count_q != RAS_FULL) ras_count_d = ras_count_q + CW'(1);
        end else if (pop) begin
            ras_count_d = ras_count_q - CW'(1);
        end
    end

`ifdef NEXT_PC_RAS_EN
    logic [PW-1:0]   ras_ptr_q, ras_ptr_d;
    logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_top;

    always_comb begin
        ras_top   = ras_mem_q[ras_ptr_q - PW'(1)];
        ras_ptr_d = ras_ptr_q;
        if (push)     ras_ptr_d = ras_ptr_q + PW'(1);
        else if (pop) ras_ptr_d = ras_ptr_q - PW'(1);
        ras_mismatch_d = pop_req & ((ras_count_q == '0) | (ras_top != io.jr_target));
    end

    always_ff @(posedge clk) begin
        if (reset) ras_ptr_q <= '0;
        else       ras_ptr_q <= ras_ptr_d;
    end

    // Entries need no reset: they are only read while ras_count is non-zero.
    always_ff @(posedge clk) begin
        if (!reset && push) ras_mem_q[ras_ptr_q] <= pc_plus4;
    end
`else
    always_comb ras_mismatch_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            ras_count_q    <= '0;
            ras_mismatch_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            ras_count_q    <= ras_count_d;
            ras_mismatch_q <= ras_mismatch_d;
        end
    end

    assign io.pc           = pc_q;
    assign io.pc_plus4     = pc_plus4;
    assign io.redirect     = ~io.stall & (taken | io.Jr | io.Jump | io.Jal);
    assign io.ras_count    = ras_count_q;
    assign io.ras_mismatch = ras_mismatch_q;
endmodule

// File: tb/tb_next_pc_seq.sv
// Bench for next_pc_seq: directed scenarios plus random control traffic against a queue-based model.
// Mismatch expectations follow NEXT_PC_RAS_EN when it is defined.
module tb_next_pc_seq;
    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    next_pc_seq_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus();

    next_pc_seq #(.XLEN(XLEN), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: PC value, return stack as a queue (newest at the back), mismatch pulse.
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        m_mis;

    function automatic logic m_taken();
        return (bus.Beq && !bus.Bne && bus.Zero) || (bus.Bne && !bus.Beq && !bus.Zero);
    endfunction

    function automatic logic exp_redirect();
        return !bus.stall && (m_taken() || bus.Jr || bus.Jump || bus.Jal);
    endfunction

    function automatic logic exp_mis();
`ifdef NEXT_PC_RAS_EN
        return m_mis;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_step();
        logic [31:0] p4;
        logic [31:0] top;
        p4    = m_pc + 32'd4;
        m_mis = 1'b0;
        if (reset) begin
            m_pc = RST_PC;
            m_ras.delete();
        end else if (!bus.stall) begin
            if (m_taken()) begin
                m_pc = p4 + bus.branch_offset * 32'd4;
            end else if (bus.Jr) begin
                if (m_ras.size() == 0) m_mis = 1'b1;
                else begin
                    top   = m_ras.pop_back();
                    m_mis = (top != bus.jr_target);
                end
                m_pc = bus.jr_target;
            end else if (bus.Jump || bus.Jal) begin
                if (bus.Jal) begin
                    m_ras.push_back(p4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
                m_pc = {p4[31:28], bus.jump_index, 2'b00};
            end else begin
                m_pc = p4;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.stall = 0; bus.Beq = 0; bus.Bne = 0; bus.Zero = 0;
        bus.Jump = 0; bus.Jal = 0; bus.Jr = 0;
        bus.branch_offset = '0; bus.jump_index = '0; bus.jr_target = '0;
    endtask

    task automatic cycle();
        model_step();
        tick();
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        clear_ctl();
        bus.Jr = 1; bus.jr_target = addr;
        cycle();
        clear_ctl();
    endtask

    task automatic do_reset();
        clear_ctl();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.pc !== RST_PC) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", bus.pc, RST_PC); end
        tests_run++; if (bus.ras_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", bus.ras_count); end
        tests_run++; if (bus.ras_mismatch !== 1'b0) begin tests_failed++; $display("FAIL reset_mis: got %b want 0", bus.ras_mismatch); end
        for (int i = 1; i <= 3; i++) begin
            #1;
            tests_run++; if (bus.redirect !== 1'b0) begin tests_failed++; $display("FAIL idle_redirect[%0d]: got %b want 0", i, bus.redirect); end
            cycle();
            tests_run++; if (bus.pc !== 32'(i * 4)) begin tests_failed++; $display("FAIL idle_pc[%0d]: got %h want %h", i, bus.pc, 32'(i * 4)); end
        end
    endtask

    task automatic test_branch();
        logic        t_beq [6] = '{1, 1, 0, 0, 1, 1};
        logic        t_bne [6] = '{0, 0, 1, 1, 1, 1};
        logic        t_z   [6] = '{1, 0, 0, 1, 1, 0};
        logic [31:0] t_off [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd8, 32'd8, 32'd8, 32'd8};
        logic [31:0] t_pc  [6] = '{32'h0FC, 32'h104, 32'h124, 32'h104, 32'h104, 32'h104};
        logic        t_rd  [6] = '{1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            goto_pc(32'h100);
            bus.Beq = t_beq[i]; bus.Bne = t_bne[i]; bus.Zero = t_z[i]; bus.branch_offset = t_off[i];
            #1;
            tests_run++; if (bus.redirect !== t_rd[i]) begin tests_failed++; $display("FAIL branch_redirect[%0d]: got %b want %b", i, bus.redirect, t_rd[i]); end
            cycle();
            tests_run++; if (bus.pc !== t_pc[i]) begin tests_failed++; $display("FAIL branch_pc[%0d]: got %h want %h", i, bus.pc, t_pc[i]); end
        end
        clear_ctl();
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        #1;
        tests_run++; if (bus.pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_plus4: got %h want 0", bus.pc_plus4); end
        cycle();
        tests_run++; if (bus.pc !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc: got %h want 0", bus.pc); end
        goto_pc(32'hFFFF_FFF0);
        bus.Beq = 1; bus.Zero = 1; bus.branch_offset = 32'd4;
        cycle();
        tests_run++; if (bus.pc !== 32'h0000_0004) begin tests_failed++; $display("FAIL wrap_branch: got %h want 00000004", bus.pc); end
        clear_ctl();
    endtask

    task automatic test_priority();
        goto_pc(32'h1000_0040);
        bus.Jump = 1; bus.Beq = 1; bus.Zero = 1; bus.branch_offset = 32'd4; bus.jump_index = 26'h3FF_FFFF;
        cycle();
        tests_run++; if (bus.pc !== 32'h1000_0054) begin tests_failed++; $display("FAIL prio_branch: got %h want 10000054", bus.pc); end
        clear_ctl();
        bus.Jr = 1; bus.Jump = 1; bus.jr_target = 32'h0000_3000; bus.jump_index = 26'h000_0010;
        cycle();
        tests_run++; if (bus.pc !== 32'h0000_3000) begin tests_failed++; $display("FAIL prio_jr: got %h want 00003000", bus.pc); end
        goto_pc(32'hF000_0000);
        bus.Jump = 1; bus.jump_index = 26'h000_0010;
        cycle();
        tests_run++; if (bus.pc !== 32'hF000_0040) begin tests_failed++; $display("FAIL jump_region: got %h want f0000040", bus.pc); end
        clear_ctl();
    endtask

    task automatic test_call_return();
        do_reset();
        goto_pc(32'h200);
        bus.Jal = 1; bus.jump_index = 26'h40;
        cycle();
        tests_run++; if (bus.pc !== 32'h100) begin tests_failed++; $display("FAIL jal_pc: got %h want 00000100", bus.pc); end
        tests_run++; if (bus.ras_count !== 3'd1) begin tests_failed++; $display("FAIL jal_count: got %0d want 1", bus.ras_count); end
        clear_ctl();
        bus.Jr = 1; bus.jr_target = 32'h204;
        cycle();
        tests_run++; if (bus.pc !== 32'h204) begin tests_failed++; $display("FAIL ret_pc: got %h want 00000204", bus.pc); end
        tests_run++; if (bus.ras_count !== 3'd0) begin tests_failed++; $display("FAIL ret_count: got %0d want 0", bus.ras_count); end
        tests_run++; if (bus.ras_mismatch !== 1'b0) begin tests_failed++; $display("FAIL ret_mis: got %b want 0", bus.ras_mismatch); end
        // Jal overridden by a taken branch: no push.
        clear_ctl();
        bus.Jal = 1; bus.Beq = 1; bus.Zero = 1; bus.branch_offset = 32'd1;
        cycle();
        tests_run++; if (bus.ras_count !== 3'd0) begin tests_failed++; $display("FAIL jal_taken_count: got %0d want 0", bus.ras_count); end
        // Push one, then Jr+Jal together: pop only.
        clear_ctl(); bus.Jal = 1; bus.jump_index = 26'h80;
        cycle();
        clear_ctl(); bus.Jr = 1; bus.Jal = 1; bus.jr_target = m_ras[$];
        cycle();
        tests_run++; if (bus.ras_count !== 3'd0) begin tests_failed++; $display("FAIL jr_jal_count: got %0d want 0", bus.ras_count); end
        tests_run++; if (bus.ras_mismatch !== 1'b0) begin tests_failed++; $display("FAIL jr_jal_mis: got %b want 0", bus.ras_mismatch); end
        clear_ctl();
    endtask

    task automatic test_ras_overflow();
        logic [2:0] want_cnt;
        logic       want_mis;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            clear_ctl(); bus.Jal = 1; bus.jump_index = 26'(i * 64);
            cycle();
            want_cnt = (i > DEPTH) ? 3'(DEPTH) : 3'(i);
            tests_run++; if (bus.ras_count !== want_cnt) begin tests_failed++; $display("FAIL push_count[%0d]: got %0d want %0d", i, bus.ras_count, want_cnt); end
        end
        for (int i = 1; i <= 5; i++) begin
            clear_ctl(); bus.Jr = 1;
            bus.jr_target = (m_ras.size() != 0) ? m_ras[$] : 32'h0000_1234;
            cycle();
            want_cnt = (i >= DEPTH) ? 3'd0 : 3'(DEPTH - i);
`ifdef NEXT_PC_RAS_EN
            want_mis = (i == 5);
`else
            want_mis = 1'b0;
`endif
            tests_run++; if (bus.ras_count !== want_cnt) begin tests_failed++; $display("FAIL pop_count[%0d]: got %0d want %0d", i, bus.ras_count, want_cnt); end
            tests_run++; if (bus.ras_mismatch !== want_mis) begin tests_failed++; $display("FAIL pop_mis[%0d]: got %b want %b", i, bus.ras_mismatch, want_mis); end
        end
        clear_ctl();
        cycle();
        tests_run++; if (bus.ras_mismatch !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse_end: got %b want 0", bus.ras_mismatch); end
    endtask

    task automatic test_stall();
        logic [31:0] hold_pc;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            clear_ctl(); bus.Jal = 1; bus.jump_index = 26'(i + 5);
            cycle();
        end
        hold_pc = m_pc;
        for (int i = 0; i < 3; i++) begin
            clear_ctl(); bus.stall = 1;
            if (i < 2) bus.Jal = 1; else bus.Jr = 1;
            #1;
            tests_run++; if (bus.redirect !== 1'b0) begin tests_failed++; $display("FAIL stall_redirect[%0d]: got %b want 0", i, bus.redirect); end
            cycle();
            tests_run++; if (bus.pc !== hold_pc) begin tests_failed++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.pc, hold_pc); end
            tests_run++; if (bus.ras_count !== 3'd2) begin tests_failed++; $display("FAIL stall_count[%0d]: got %0d want 2", i, bus.ras_count); end
            tests_run++; if (bus.ras_mismatch !== 1'b0) begin tests_failed++; $display("FAIL stall_mis[%0d]: got %b want 0", i, bus.ras_mismatch); end
        end
        clear_ctl(); bus.Jal = 1; bus.jump_index = 26'h33; reset = 1;
        cycle();
        reset = 0;
        tests_run++; if (bus.pc !== RST_PC) begin tests_failed++; $display("FAIL reset_jal_pc: got %h want %h", bus.pc, RST_PC); end
        tests_run++; if (bus.ras_count !== 3'd0) begin tests_failed++; $display("FAIL reset_jal_count: got %0d want 0", bus.ras_count); end
        clear_ctl();
    endtask

    task automatic test_random();
        int sel;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            clear_ctl();
            reset     = ($urandom_range(0, 79) == 0);
            bus.stall = ($urandom_range(0, 7) == 0);
            bus.Zero  = 1'($urandom);
            bus.branch_offset = 32'($urandom_range(0, 255)) - 32'd128;
            bus.jump_index    = 26'($urandom);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: begin bus.Beq = 1; bus.Bne = ($urandom_range(0, 3) == 0); end
                2:    bus.Bne = 1;
                3, 4: begin bus.Jal = 1; bus.Jr = ($urandom_range(0, 5) == 0); end
                5, 6: bus.Jr = 1;
                7:    bus.Jump = 1;
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) bus.Jal = 1;
            if (m_ras.size() != 0 && $urandom_range(0, 2) != 0) bus.jr_target = m_ras[$];
            else bus.jr_target = $urandom & 32'hFFFF_FFFC;
            #1;
            tests_run++; if (bus.redirect !== exp_redirect()) begin tests_failed++; $display("FAIL rnd_redirect[%0d]: got %b want %b", n, bus.redirect, exp_redirect()); end
            tests_run++; if (bus.pc_plus4 !== m_pc + 32'd4) begin tests_failed++; $display("FAIL rnd_plus4[%0d]: got %h want %h", n, bus.pc_plus4, m_pc + 32'd4); end
            cycle();
            tests_run++; if (bus.pc !== m_pc) begin tests_failed++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, bus.pc, m_pc); end
            tests_run++; if (bus.ras_count !== 3'(m_ras.size())) begin tests_failed++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, bus.ras_count, m_ras.size()); end
            tests_run++; if (bus.ras_mismatch !== exp_mis()) begin tests_failed++; $display("FAIL rnd_mis[%0d]: got %b want %b", n, bus.ras_mismatch, exp_mis()); end
        end
        reset = 0;
        clear_ctl();
    endtask

    initial begin
        reset = 1;
        clear_ctl();
        test_reset();
        test_branch();
        test_wrap();
        test_priority();
        test_call_return();
        test_ras_overflow();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
